seq_alu_acc: RTL and testbench
==============================

// Module: seq_alu_acc
// PURPOSE
//  Registered, handshaked N-bit ALU with an accumulator and a Z/N/C/V flag register.
//  Superset of the combinational ALU op set: adds carry-chained ops, barrel shifts and a multi-cycle shift-add multiply.
//  Sits between an operand source (valid/ready) and a result sink (valid/ready); lab-datapath building block.
// PARAMETERS
//  N     8            datapath width; power of 2, N >= 4
//  SW    $clog2(N)    shift-amount width (derived; do not override)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    op/operands valid
//  in_ready   out  1    block can accept an op this cycle
//  op         in   4    opcode (table below)
//  use_acc    in   1    1: operand A taken from accumulator instead of port a
//  a          in   N    operand A
//  b          in   N    operand B
//  out_valid  out  1    y/flags valid
//  out_ready  in   1    sink accepts result
//  y          out  N    result (also mirrors accumulator)
//  flags      out  4    {Z,N,C,V} of last result
//  busy       out  1    multiply in progress
// BEHAVIOUR
//  Reset (async, rst_n=0): y=0, flags=0, acc=0, out_valid=0, busy=0, FSM=IDLE. Mid-multiply reset aborts the op with no result.
//  Accept = in_valid & in_ready; in_ready = ~busy & (~out_valid | out_ready), so back-to-back single-cycle ops are supported.
//  Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 INC A, 7 DEC A, 8 ADC (A+B+C), 9 SBB (A-B-C),
//       A SHL, B SHR logical, C SRA (shift amount = b[SW-1:0]), D MUL (low N bits), E CLR (y=0), F LDB (y=B).
//  Single-cycle ops: the result is registered on the accept edge; out_valid=1 in the next cycle (latency 1).
//  MUL: FSM IDLE->MUL on accept; N shift-add iterations, one per cycle; then y/flags load and FSM returns to IDLE.
//       out_valid rises N+1 cycles after the accept edge; busy=1 and in_ready=0 for that whole span.
//  On every result load: acc<=y; flags are updated. Between results, flags and acc hold.
//  Arithmetic is computed at N+1 bits.
//  C flag:
//    ADD/ADC/INC: carry-out.
//    SUB/SBB/DEC: borrow (1 when the unsigned minuend < subtrahend [+C]).
//    Shifts: last bit shifted out; 0 when amount=0.
//    MUL: 1 when the upper N bits of the 2N-bit product are nonzero.
//    Logic/CLR/LDB: 0.
//  V flag: signed overflow for ADD/SUB/ADC/SBB/INC/DEC; 0 otherwise.
//  Z flag: y==0. N flag: y[N-1].
//  Backpressure: while out_valid & ~out_ready, y/flags/out_valid are held stable and no op is accepted.
//  out_valid drops after the handshake unless a new op is accepted on the same edge.
//  Simultaneous output handshake and input accept: the new result replaces the old one and out_valid stays 1.
//  ADC/SBB use the flag C from the previous result; after reset, C=0.
//  Undefined opcodes: none (all 16 defined).
// STRUCTURE
//  Package seq_alu_pkg: opcode localparams (OP_ADD..OP_LDB), flag bit indices (FZ,FN,FC,FV), FSM state encoding (IDLE, MUL).
//  Sub-module alu_core: purely combinational single-cycle ops, producing {c,v,y} from (op,a,b,cin).
//  The top level holds the handshake, acc/flag registers, the MUL FSM, and the multiplicand/multiplier/partial-product registers.
// TESTING (N=8)
//  - ADD a=FF b=01 -> next cycle y=00, flags Z=1 N=0 C=1 V=0, out_valid=1.
//  - SUB a=80 b=01 -> y=7F, V=1, C=0. Then SUB a=00 b=01 -> y=FF, C=1, N=1.
//  - ADD FF+01, then ADC use_acc=1 b=00 -> y=01 (carry chained), C=0.
//  - MUL a=0D b=0B -> y=8F, C=0, out_valid exactly 9 cycles after accept; in_ready=0 throughout.
//    MUL a=14 b=14 -> y=90, C=1.
//  - Hold out_ready=0 and drive two ops -> second op not accepted, y stable; raising out_ready accepts it on that edge.
//  - Drop rst_n at cycle 3 of a MUL -> y/flags/out_valid/busy=0 immediately; in_ready=1 after release.
//    SRA a=90 b=03 -> y=F2, C=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_DEC = 4'h7;
    localparam logic [3:0] OP_ADC = 4'h8;
    localparam logic [3:0] OP_SBB = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_SRA = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_CLR = 4'hE;
    localparam logic [3:0] OP_LDB = 4'hF;

    // flags = {Z,N,C,V}
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f     = '0;
        f[FZ] = z;
        f[FN] = n;
        f[FC] = c;
        f[FV] = v;
        return f;
    endfunction

endpackage

// File: rtl/seq_alu_acc_core.sv
// Combinational single-cycle ALU ops; MUL is sequenced by the top level.
module alu_core
    import seq_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] y,
    output logic         c,
    output logic         v
);
    localparam int SW = $clog2(N);

    logic [N-1:0]  w_rhs;
    logic          w_ci;
    logic          w_sub;
    logic [N:0]    w_arith;
    logic          w_ovf;
    logic [SW-1:0] w_amt;
    logic [N:0]    w_shl;
    logic [N:0]    w_shr;
    logic [N:0]    w_sra;

    // One N+1-bit adder/subtractor serves all arithmetic ops; bit N is carry or borrow.
    always_comb begin
        w_rhs = b;
        w_ci  = 1'b0;
        w_sub = 1'b0;
        case (op)
            OP_SUB: w_sub = 1'b1;
            OP_INC: w_rhs = {{(N-1){1'b0}}, 1'b1};
            OP_DEC: begin
                w_rhs = {{(N-1){1'b0}}, 1'b1};
                w_sub = 1'b1;
            end
            OP_ADC: w_ci = cin;
            OP_SBB: begin
                w_ci  = cin;
                w_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_arith = w_sub ? ({1'b0, a} - {1'b0, w_rhs} - {{N{1'b0}}, w_ci})
                           : ({1'b0, a} + {1'b0, w_rhs} + {{N{1'b0}}, w_ci});
    assign w_ovf   = w_sub ? ((a[N-1] != w_rhs[N-1]) && (w_arith[N-1] != a[N-1]))
                           : ((a[N-1] == w_rhs[N-1]) && (w_arith[N-1] != a[N-1]));

    // An extra guard bit catches the last bit shifted out (stays 0 for amount 0).
    assign w_amt = b[SW-1:0];
    assign w_shl = {1'b0, a} << w_amt;
    assign w_shr = {a, 1'b0} >> w_amt;
    assign w_sra = $unsigned($signed({a, 1'b0}) >>> w_amt);

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBB: begin
                y = w_arith[N-1:0];
                c = w_arith[N];
                v = w_ovf;
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = w_shl[N-1:0];
                c = w_shl[N];
            end
            OP_SHR: begin
                y = w_shr[N:1];
                c = w_shr[0];
            end
            OP_SRA: begin
                y = w_sra[N:1];
                c = w_sra[0];
            end
            OP_LDB: y = b;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu_acc.sv
// Handshaked ALU with accumulator, Z/N/C/V flags and a shift-add multiplier FSM.
module seq_alu_acc
    import seq_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic         use_acc,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [3:0]   flags,
    output logic         busy
);
    localparam int CW = $clog2(N + 1);

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_acc;
    logic [3:0]     r_flags;
    logic           r_ov;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_mplier;
    logic [2*N-1:0] r_prod;

    logic           w_ld_single;
    logic           w_mul_start;
    logic           w_mul_step;
    logic           w_mul_done;
    logic [N-1:0]   w_opa;
    logic [N-1:0]   w_core_y;
    logic           w_core_c;
    logic           w_core_v;

    assign w_opa = use_acc ? r_acc : a;

    alu_core #(.N(N)) u_core (
        .op  (op),
        .a   (w_opa),
        .b   (b),
        .cin (r_flags[FC]),
        .y   (w_core_y),
        .c   (w_core_c),
        .v   (w_core_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // MUL spends N cycles iterating and one more loading the result.
    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        w_ld_single = 1'b0;
        w_mul_start = 1'b0;
        w_mul_step  = 1'b0;
        w_mul_done  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~r_ov | out_ready;
                if (in_valid && in_ready) begin
                    if (op == OP_MUL) begin
                        w_mul_start = 1'b1;
                        w_next      = MUL;
                    end else begin
                        w_ld_single = 1'b1;
                    end
                end
            end
            MUL: begin
                busy = 1'b1;
                if (r_cnt == CW'(N)) begin
                    w_mul_done = 1'b1;
                    w_next     = IDLE;
                end else begin
                    w_mul_step = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_flags <= '0;
            r_ov    <= 1'b0;
        end else if (w_ld_single) begin
            r_acc   <= w_core_y;
            r_flags <= pack_flags(w_core_y == '0, w_core_y[N-1], w_core_c, w_core_v);
            r_ov    <= 1'b1;
        end else if (w_mul_done) begin
            r_acc   <= r_prod[N-1:0];
            r_flags <= pack_flags(r_prod[N-1:0] == '0, r_prod[N-1],
                                  |r_prod[2*N-1:N], 1'b0);
            r_ov    <= 1'b1;
        end else if (out_ready) begin
            r_ov    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (w_mul_start) begin
            r_cnt    <= '0;
            r_mcand  <= {{N{1'b0}}, w_opa};
            r_mplier <= b;
            r_prod   <= '0;
        end else if (w_mul_step) begin
            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign y         = r_acc;
    assign flags     = r_flags;
    assign out_valid = r_ov;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Directed-vector bench for seq_alu_acc at N=8; expected values are hand-computed.
module tb_seq_alu_acc;
    import seq_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'h0;
    logic       use_acc = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic [3:0] flags;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu_acc #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_acc   (use_acc),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Present an op, wait (bounded) for acceptance; returns #1 after the accept edge.
    task automatic send(input logic [3:0] o, input logic ua, input logic [7:0] va,
                        input logic [7:0] vb);
        int k;
        @(negedge clk);
        op = o; use_acc = ua; a = va; b = vb; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        use_acc  = 1'b0;
    endtask

    initial begin
        int  k;
        logic saw_rdy;

        repeat (2) @(negedge clk);
        chk("rst_y", y, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inready", in_ready, 1'b1);

        send(OP_ADD, 1'b0, 8'hFF, 8'h01);
        chk("add_y", y, 8'h00);
        chk("add_flags", flags, 4'b1010);
        chk("add_ovalid", out_valid, 1'b1);

        send(OP_SUB, 1'b0, 8'h80, 8'h01);
        chk("sub1_y", y, 8'h7F);
        chk("sub1_flags", flags, 4'b0001);
        send(OP_SUB, 1'b0, 8'h00, 8'h01);
        chk("sub2_y", y, 8'hFF);
        chk("sub2_flags", flags, 4'b0110);

        send(OP_ADD, 1'b0, 8'hFF, 8'h01);
        send(OP_ADC, 1'b1, 8'h00, 8'h00);
        chk("adc_y", y, 8'h01);
        chk("adc_flags", flags, 4'b0000);

        send(OP_INC, 1'b0, 8'h7F, 8'h00);
        chk("inc_y", y, 8'h80);
        chk("inc_flags", flags, 4'b0101);
        send(OP_DEC, 1'b0, 8'h00, 8'h00);
        chk("dec_y", y, 8'hFF);
        chk("dec_flags", flags, 4'b0110);
        send(OP_SBB, 1'b0, 8'h05, 8'h02);
        chk("sbb_y", y, 8'h02);
        chk("sbb_flags", flags, 4'b0000);
        send(OP_SHL, 1'b0, 8'h81, 8'h01);
        chk("shl_y", y, 8'h02);
        chk("shl_flags", flags, 4'b0010);
        send(OP_XOR, 1'b0, 8'hA5, 8'hFF);
        chk("xor_y", y, 8'h5A);

        // MUL latency and in_ready/busy during the multiply
        send(OP_MUL, 1'b0, 8'h0D, 8'h0B);
        chk("mul_busy", busy, 1'b1);
        chk("mul_ovalid_low", out_valid, 1'b0);
        k = 0;
        saw_rdy = 1'b0;
        while (!out_valid && k < 20) begin
            if (in_ready) saw_rdy = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        chk("mul_latency", k, 9);
        chk("mul_inready_low", saw_rdy, 1'b0);
        chk("mul_y", y, 8'h8F);
        chk("mul_flags", flags, 4'b0100);
        chk("mul_busy_done", busy, 1'b0);

        send(OP_MUL, 1'b0, 8'h14, 8'h14);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("mul2_latency", k, 9);
        chk("mul2_y", y, 8'h90);
        chk("mul2_flags", flags, 4'b0110);

        // Backpressure: second op held off while the sink stalls
        send(OP_LDB, 1'b0, 8'h00, 8'h55);
        @(negedge clk);
        out_ready = 1'b0;
        op = OP_ADD; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_inready", in_ready, 1'b0);
        chk("bp_y", y, 8'h55);
        chk("bp_ovalid", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("bp_inready_release", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_y_new", y, 8'h03);
        chk("bp_ovalid_new", out_valid, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_ovalid_drop", out_valid, 1'b0);

        // Reset in the middle of a multiply aborts it
        send(OP_MUL, 1'b0, 8'h03, 8'h03);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_y", y, 8'h00);
        chk("mrst_flags", flags, 4'h0);
        chk("mrst_ovalid", out_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_inready", in_ready, 1'b1);
        saw_rdy = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_rdy = 1'b1;
        end
        chk("mrst_no_result", saw_rdy, 1'b0);

        send(OP_SRA, 1'b0, 8'h90, 8'h03);
        chk("sra_y", y, 8'hF2);
        chk("sra_flags", flags, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
